// File: rtl/servo_pkg.sv
// Shared constants, position-to-width table and slot FSM encoding for the
// four-channel servo frame scheduler.
package servo_pkg;

  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned SLOT_CYC  = 250_000;
  localparam int unsigned RAMP_STEP = 5_000;
  localparam int unsigned WIDTH_W   = 17;
  localparam int unsigned POS_W     = 3;
  localparam int unsigned CH_W      = 2;
  localparam int unsigned NUM_POS   = 5;
  localparam int unsigned MID_POS   = 2;
  localparam int unsigned STATE_W   = 1;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t PULSE_HI = 1'b0;
  localparam state_t PULSE_LO = 1'b1;

  // Position n maps to (n+1) tenths of a slot: 25k/50k/75k/100k/125k at 250k-cycle slots.
  function automatic logic [WIDTH_W-1:0] pos_to_width(input logic [POS_W-1:0] pos,
                                                      input int unsigned slot_cyc);
    int unsigned w;
    w = (32'(pos) + 32'd1) * (slot_cyc / 32'd10);
    return WIDTH_W'(w);
  endfunction

  function automatic logic pos_legal(input logic [POS_W-1:0] pos);
    return 32'(pos) < NUM_POS;
  endfunction

endpackage

// File: rtl/servo_ramp.sv
// Per-channel slew limiter: at each frame boundary cur_w steps toward tgt_w
// by at most STEP cycles and then holds for the whole frame.
module servo_ramp
  import servo_pkg::*;
#(
  parameter int unsigned STEP   = servo_pkg::RAMP_STEP,
  parameter int unsigned INIT_W = 75_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               boundary,
  input  logic [WIDTH_W-1:0] tgt_w,
  output logic [WIDTH_W-1:0] cur_w
);

  localparam logic [WIDTH_W-1:0] STEP_W = WIDTH_W'(STEP);

  logic               up_c;
  logic [WIDTH_W-1:0] diff_c;
  logic [WIDTH_W-1:0] delta_c;
  logic [WIDTH_W-1:0] next_c;

  // Step is min(STEP, |tgt - cur|), so the ramp lands exactly on the target.
  always_comb begin
    up_c    = tgt_w > cur_w;
    diff_c  = up_c ? (tgt_w - cur_w) : (cur_w - tgt_w);
    delta_c = (diff_c > STEP_W) ? STEP_W : diff_c;
    next_c  = up_c ? (cur_w + delta_c) : (cur_w - delta_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_w <= WIDTH_W'(INIT_W);
    end else if (boundary) begin
      cur_w <= next_c;
    end
  end

endmodule

// File: rtl/servo_frame_sched.sv
// Servo frame scheduler: one PWM pulse per channel per frame, each in its own
// slot, with a single-entry command buffer applied at frame boundaries.
module servo_frame_sched
  import servo_pkg::*;
#(
  parameter int unsigned NUM_CH    = servo_pkg::NUM_CH,
  parameter int unsigned SLOT_CYC  = servo_pkg::SLOT_CYC,
  parameter int unsigned RAMP_STEP = servo_pkg::RAMP_STEP
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [POS_W-1:0]  cmd_pos,
  output logic [NUM_CH-1:0] PWM,
  output logic [NUM_CH-1:0] busy,
  output logic              frame_tick,
  output logic              err
);

  localparam int unsigned CNT_W      = $clog2(SLOT_CYC);
  localparam int unsigned SLOT_IDX_W = $clog2(NUM_CH);
  localparam int unsigned INIT_W     = 32'(pos_to_width(POS_W'(MID_POS), SLOT_CYC));

  // Frame position of the cycle currently on the outputs.
  logic                  run;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [SLOT_IDX_W-1:0] slot;
  logic [SLOT_IDX_W-1:0] slot_nxt;
  state_t                state;
  state_t                state_nxt;
  logic                  boundary_c;
  logic [NUM_CH-1:0]     pwm_nxt;

  // Command buffer and per-channel widths.
  logic                  pending;
  logic                  pending_nxt;
  logic [CH_W-1:0]       pend_ch;
  logic [WIDTH_W-1:0]    pend_w;
  logic                  accept_c;
  logic                  legal_c;
  logic [WIDTH_W-1:0]    tgt_w   [NUM_CH];
  logic [WIDTH_W-1:0]    tgt_nxt [NUM_CH];
  logic [WIDTH_W-1:0]    cur_w   [NUM_CH];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= PULSE_HI;
      cnt   <= '0;
      slot  <= '0;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      slot  <= slot_nxt;
      run   <= 1'b1;
    end
  end

  // The first edge after reset lands on frame cycle 0 instead of advancing.
  always_comb begin
    cnt_nxt   = '0;
    slot_nxt  = '0;
    state_nxt = PULSE_HI;
    if (run) begin
      if (cnt == CNT_W'(SLOT_CYC - 1)) begin
        slot_nxt  = (slot == SLOT_IDX_W'(NUM_CH - 1)) ? '0 : slot + SLOT_IDX_W'(1);
        state_nxt = PULSE_HI;
      end else begin
        cnt_nxt   = cnt + CNT_W'(1);
        slot_nxt  = slot;
        state_nxt = state;
        if (state == PULSE_HI && 32'(cnt_nxt) == 32'(cur_w[slot])) begin
          state_nxt = PULSE_LO;
        end
      end
    end
    boundary_c = (slot_nxt == '0) && (cnt_nxt == '0);
    pwm_nxt    = '0;
    if (state_nxt == PULSE_HI) begin
      pwm_nxt[slot_nxt] = 1'b1;
    end
  end

  // Only the entry pending before the boundary edge is applied at that edge.
  always_comb begin
    accept_c    = cmd_valid && cmd_ready;
    legal_c     = pos_legal(cmd_pos);
    pending_nxt = pending;
    if (accept_c && legal_c) begin
      pending_nxt = 1'b1;
    end else if (boundary_c) begin
      pending_nxt = 1'b0;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      tgt_nxt[k] = tgt_w[k];
    end
    if (boundary_c && pending) begin
      tgt_nxt[pend_ch] = pend_w;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pending    <= 1'b0;
      pend_ch    <= '0;
      pend_w     <= '0;
      cmd_ready  <= 1'b0;
      err        <= 1'b0;
      frame_tick <= 1'b0;
      PWM        <= '0;
      busy       <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        tgt_w[k] <= WIDTH_W'(INIT_W);
      end
    end else begin
      pending    <= pending_nxt;
      cmd_ready  <= !pending_nxt;
      err        <= accept_c && !legal_c;
      frame_tick <= boundary_c;
      PWM        <= pwm_nxt;
      if (accept_c && legal_c) begin
        pend_ch <= cmd_ch;
        pend_w  <= pos_to_width(cmd_pos, SLOT_CYC);
      end
      for (int k = 0; k < NUM_CH; k++) begin
        tgt_w[k] <= tgt_nxt[k];
        busy[k]  <= cur_w[k] != tgt_w[k];
      end
    end
  end

  // Ramps see the post-update target so a new command slews in the same frame.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    servo_ramp #(
      .STEP   (RAMP_STEP),
      .INIT_W (INIT_W)
    ) u_ramp (
      .clk      (CLK),
      .rst      (RST),
      .boundary (boundary_c),
      .tgt_w    (tgt_nxt[k]),
      .cur_w    (cur_w[k])
    );
  end

endmodule

// File: doc/servo_frame_sched.md
SERVO_FRAME_SCHED -- requirements
Module: servo_frame_sched

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of servo channels (fixed at 4 for this release).
REQ-002 SHALL have parameter SLOT_CYC, default 250_000, CLK cycles per channel slot (5 ms at 50 MHz).
REQ-003 SHALL have parameter RAMP_STEP, default 5_000, maximum pulse-width change per channel per frame, in CLK cycles.
REQ-004 CLK  input  1  system clock, 50 MHz.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 cmd_valid  input  1  position command offered.
REQ-007 cmd_ready  output  1  block can accept a command.
REQ-008 cmd_ch  input  2  target channel, 0..3.
REQ-009 cmd_pos  input  3  position index: 0..4 = 0/45/90/135/180 deg.
REQ-010 PWM  output  4  servo pulse per channel, bit k = channel k.
REQ-011 busy  output  4  bit k high while channel k width differs from its target.
REQ-012 frame_tick  output  1  one-cycle pulse at each frame boundary.
REQ-013 err  output  1  one-cycle pulse when a command with an illegal position is dropped.

Function
REQ-014 Frame SHALL be NUM_CH*SLOT_CYC = 1_000_000 cycles (20 ms), split into slots 0..3; frame cycle 0 is the first CLK edge after RST deasserts.
REQ-015 PWM[k] SHALL be high for exactly cur_w[k] cycles starting at frame cycle k*SLOT_CYC, and low otherwise.
REQ-016 Width table SHALL be pos0=25_000, pos1=50_000, pos2=75_000, pos3=100_000, pos4=125_000 cycles; widths are 17 bits, unsigned.
REQ-017 Per-slot FSM SHALL have states PULSE_HI and PULSE_LO: PULSE_HI->PULSE_LO when the slot counter reaches cur_w; PULSE_LO->PULSE_HI of the next slot when the slot counter reaches SLOT_CYC-1; slot index wraps 3->0.
REQ-018 Command buffer SHALL hold one pending entry; cmd_ready = not pending; a transfer occurs on cmd_valid && cmd_ready at a CLK edge.
REQ-019 cmd_pos > 4 SHALL complete the handshake, not set pending, and pulse err in the following cycle.
REQ-020 At the frame boundary (frame cycle 0), the pending entry SHALL write tgt_w[cmd_ch], pending SHALL clear, and cmd_ready SHALL be high from the next cycle.
REQ-021 A command accepted in the boundary cycle itself SHALL be applied at the following boundary.
REQ-022 At each boundary, after the target update, each channel SHALL slew: cur_w moves toward tgt_w by min(RAMP_STEP, |tgt_w-cur_w|); the new cur_w governs that whole frame.
REQ-023 A new target on a channel mid-ramp SHALL redirect the ramp from the current width with no extra delay.
REQ-024 busy[k] SHALL equal (cur_w[k] != tgt_w[k]), registered.
REQ-025 frame_tick SHALL be high exactly in frame cycle 0.

Reset
REQ-026 While RST is high: PWM=0, busy=0, err=0, frame_tick=0, cmd_ready=0, pending=0, all cur_w=tgt_w=75_000, slot=0, counter=0, FSM in PULSE_HI.
REQ-027 Assertion mid-pulse SHALL drive PWM low immediately (asynchronous); a pending command SHALL be discarded.
REQ-028 cmd_ready SHALL go high on the first CLK edge after RST deasserts.

Structure
REQ-029 Package servo_pkg SHALL hold NUM_CH, SLOT_CYC, RAMP_STEP, WIDTH_W=17, the position-to-width table and the FSM state type.
REQ-030 The per-channel slew limiter SHALL be sub-module servo_ramp (inputs tgt_w, boundary strobe; output cur_w), instantiated NUM_CH times.

Verification
REQ-031 Reset then idle for 3 frames -> each PWM[k] high 75_000 cycles from k*250_000; frame_tick every 1_000_000 cycles; busy=0.
REQ-032 cmd ch2 pos4 -> widths on PWM[2] are 80_000, 85_000, ..., 125_000 over 10 frames; busy[2] drops in the frame reaching 125_000.
REQ-033 cmd ch1 pos7 -> err pulses once, no width change, cmd_ready stays high.
REQ-034 Two back-to-back commands (ch0 pos0, ch3 pos4) -> cmd_ready low until the first boundary; ch0 ramps from frame 1, ch3 from frame 2.
REQ-035 ch0 pos4, then ch0 pos0 after 3 frames -> widths 80k, 85k, 90k, then 85k down to 25k in 5k steps.
REQ-036 RST pulsed during the PWM[1] high time -> PWM[1] low same cycle; after release all widths are 75_000 and the pending command is lost.
